multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle control sequencer for the RV32I datapath: steps one instruction at a time through fetch, decode, execute, memory and writeback. It emits one-cycle enable strobes for the PC, instruction register, register file and shared memory port. A single memory port is shared between instruction fetch and data access. Sits between the decoder/control unit and the IFU, register file and memory, replacing the implicit single-cycle timing.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles to wait for `mem_ready` in FETCH or MEM; legal range 1..255.
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 7: opcode from the decoder, taken from the instruction register.
- `mem_ready` in 1: memory completes the current request when sampled high at a rising edge with `mem_req`=1.
- `halt_req` in 1: request to stop at the next instruction boundary.
- `state` out 3: current state, encoded IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- `mem_req` out 1: memory request, valid in FETCH and MEM.
- `mem_we` out 1: write qualifier; 1 only in MEM for a store.
- `mem_is_fetch` out 1: memory address select; 1 selects PC, 0 selects ALU result.
- `ir_write_en` out 1: load the instruction register.
- `pc_write_en` out 1: advance the PC.
- `regwrite_en` out 1: register-file write strobe.
- `retired` out 1: one-cycle pulse per completed instruction.
- `retire_count` out RETIRE_W: count of retired instructions.
- `illegal_op` out 1: sticky flag; unsupported opcode was seen.
- `bus_error` out 1: sticky flag; memory timeout occurred.

## Operation
**Reset (`reset`=0, asynchronous)**
- `state`=IDLE.
- `retire_count`=0.
- All other outputs 0, including the sticky flags.
- Opcode class register cleared.

**IDLE**
- Goes to FETCH on the first edge after reset release.

**FETCH**
- Drives `mem_req`=1 and `mem_is_fetch`=1.
- Stays until `mem_ready`=1, then goes to DECODE.
- `ir_write_en` and `pc_write_en` are high during the accepting cycle only.

**DECODE** (1 cycle)
- Classifies `opcode` into a registered class:
  - R-ALU 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
- Any other opcode sets `illegal_op` and goes to HALT.
- A legal opcode goes to EXECUTE.

**EXECUTE** (1 cycle)
- LOAD or STORE goes to MEM.
- R-ALU or I-ALU goes to WRITEBACK.

**MEM**
- Drives `mem_req`=1 and `mem_is_fetch`=0, with `mem_we` = (class==STORE).
- Waits for `mem_ready`.
- LOAD then goes to WRITEBACK.
- STORE retires here.

**WRITEBACK** (1 cycle)
- Drives `regwrite_en`=1.
- The instruction retires.

**Retire**
- Pulses `retired` for one cycle.
- Increments `retire_count`, wrapping from 2^RETIRE_W−1 to 0.
- Next state is HALT if `halt_req`=1 in the retiring cycle, else FETCH.

**HALT**
- `state` output reads 6.
- If `illegal_op` or `bus_error` is set: stays in HALT until reset.
- Otherwise: returns to FETCH on the first edge where `halt_req`=0.

**Other rules**
- `halt_req` is ignored outside the retire cycle and HALT; an instruction in flight always completes.
- All control outputs are Moore: decoded from `state` and the class register, never from `mem_ready`.
  - Exceptions: `ir_write_en`, `pc_write_en` and `retired`, which are qualified by `mem_ready` in the accepting cycle.

## Timing
- Minimum latency with `mem_ready` tied to 1:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Store: 4 cycles (FETCH, DECODE, EXECUTE, MEM).
  - Load: 5 cycles.
- Each wait-state cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `mem_req` stays high continuously from entry into FETCH/MEM until the accepting edge. It drops the following cycle unless the next state is also a request state.
  - Example: store retire to FETCH keeps `mem_req` at 1, while `mem_is_fetch` switches from 0 to 1.
- Simultaneous `mem_ready` and timeout expiry: `mem_ready` wins.
- Reset asserted mid-instruction aborts immediately. No strobe is emitted after reset falls.

## Configuration
- `SEQ_MEM_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH/MEM and counts cycles with `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT`, `bus_error` is set and the next state is HALT; no strobes are issued for that access.
- Not defined:
  - No counter is built; the sequencer waits indefinitely.
  - `bus_error` is tied to 0.

## Test plan
- **ALU retire:** `mem_ready`=1, opcode 0110011 → states 1,2,3,5,1. `regwrite_en` high in cycle 4 only, `retired` pulses once, `retire_count`=1.
- **Load with waits:** opcode 0000011, `mem_ready` low for 2 cycles in MEM → 7 cycles total. `mem_we`=0, `mem_is_fetch`=0 in MEM, `regwrite_en` in the last cycle.
- **Store:** opcode 0100011 → `mem_we`=1 for exactly the MEM cycle, no `regwrite_en`, 4 cycles total, `retire_count` increments.
- **Illegal opcode:** opcode 1111111 → HALT after DECODE with `illegal_op`=1. Toggling `halt_req` does not leave HALT; only reset recovers.
- **Timeout:** with `SEQ_MEM_TIMEOUT_EN` defined, `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH → HALT after 4 cycles, `bus_error`=1, `ir_write_en` never asserted. Without the macro, the sequencer stays in FETCH.
- **Halt and reset:** `halt_req`=1 during an ALU WRITEBACK → HALT, resume to FETCH one cycle after `halt_req`=0. Asserting `reset` in MEM forces state 0 and `mem_req`=0 within the same cycle.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared memory port.
// Define SEQ_MEM_TIMEOUT_EN to bound mem_ready waits; a timeout sets bus_error and halts.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                halt_req,
  output logic [2:0]          state,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_is_fetch,
  output logic                ir_write_en,
  output logic                pc_write_en,
  output logic                regwrite_en,
  output logic                retired,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                illegal_op,
  output logic                bus_error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {C_RALU, C_IALU, C_LOAD, C_STORE} class_t;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be within 1..255");
  end

  state_t              r_state;
  state_t              w_next;
  class_t              r_class;
  class_t              w_dec_class;
  logic                w_dec_legal;
  logic                w_in_req;
  logic                w_timeout;
  logic                w_retire;
  logic                w_bus_error;
  logic                r_illegal;
  logic                r_mem_req;
  logic                r_mem_we;
  logic                r_mem_is_fetch;
  logic                r_regwrite;
  logic [RETIRE_W-1:0] r_retire_cnt;

  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_class = C_RALU;
    case (opcode)
      7'b0110011: w_dec_class = C_RALU;
      7'b0010011: w_dec_class = C_IALU;
      7'b0000011: w_dec_class = C_LOAD;
      7'b0100011: w_dec_class = C_STORE;
      default:    w_dec_legal = 1'b0;
    endcase
  end

  assign w_in_req = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_MEM) && (r_class == C_STORE) && mem_ready);

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] r_wait;
  logic       r_bus_error;

  // mem_ready takes priority over an expiring wait count.
  assign w_timeout   = w_in_req && !mem_ready && (r_wait == 8'(MEM_TIMEOUT - 1));
  assign w_bus_error = r_bus_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait      <= 8'd0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_in_req && !mem_ready && !w_timeout) r_wait <= r_wait + 8'd1;
      else                                      r_wait <= 8'd0;
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_bus_error = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH:   if (mem_ready)      w_next = S_DECODE;
                 else if (w_timeout) w_next = S_HALT;
      S_DECODE:  w_next = w_dec_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: w_next = ((r_class == C_LOAD) || (r_class == C_STORE)) ? S_MEM : S_WB;
      S_MEM:     if (mem_ready)      w_next = (r_class == C_STORE) ? (halt_req ? S_HALT : S_FETCH) : S_WB;
                 else if (w_timeout) w_next = S_HALT;
      S_WB:      w_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:    if (!r_illegal && !w_bus_error && !halt_req) w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_class        <= C_RALU;
      r_illegal      <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_is_fetch <= 1'b0;
      r_regwrite     <= 1'b0;
      r_retire_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
        if (!w_dec_legal) r_illegal <= 1'b1;
      end
      r_mem_req      <= (w_next == S_FETCH) || (w_next == S_MEM);
      r_mem_is_fetch <= (w_next == S_FETCH);
      r_mem_we       <= (w_next == S_MEM) && (r_class == C_STORE);
      r_regwrite     <= (w_next == S_WB);
      if (w_retire) r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign state        = r_state;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_is_fetch = r_mem_is_fetch;
  assign regwrite_en  = r_regwrite;
  assign ir_write_en  = (r_state == S_FETCH) && mem_ready;
  assign pc_write_en  = (r_state == S_FETCH) && mem_ready;
  assign retired      = w_retire;
  assign retire_count = r_retire_cnt;
  assign illegal_op   = r_illegal;
  assign bus_error    = w_bus_error;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized instruction stream against a per-instruction timeline model, plus illegal/timeout/reset cases.
module tb_multicycle_sequencer;
  localparam int TO = 4;
  localparam int RW = 4;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          halt_req;
  logic [2:0]    state;
  logic          mem_req, mem_we, mem_is_fetch, ir_write_en, pc_write_en;
  logic          regwrite_en, retired, illegal_op, bus_error;
  logic [RW-1:0] retire_count;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt;
  logic exp_ill, exp_berr;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .state(state), .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
    .ir_write_en(ir_write_en), .pc_write_en(pc_write_en), .regwrite_en(regwrite_en),
    .retired(retired), .retire_count(retire_count), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic [2:0] st, input logic rdy, input logic [6:0] op);
    logic req, ret;
    req = (st == 3'd1) || (st == 3'd4);
    ret = (st == 3'd5) || ((st == 3'd4) && (op == OP_ST) && rdy);
    check_eq("state", 32'(state), 32'(st));
    check_eq("mem_req", 32'(mem_req), 32'(req));
    check_eq("mem_is_fetch", 32'(mem_is_fetch), 32'(st == 3'd1));
    check_eq("mem_we", 32'(mem_we), 32'((st == 3'd4) && (op == OP_ST)));
    check_eq("regwrite_en", 32'(regwrite_en), 32'(st == 3'd5));
    check_eq("ir_write_en", 32'(ir_write_en), 32'((st == 3'd1) && rdy));
    check_eq("pc_write_en", 32'(pc_write_en), 32'((st == 3'd1) && rdy));
    check_eq("retired", 32'(retired), 32'(ret));
    check_eq("retire_count", 32'(retire_count), 32'(exp_cnt));
    check_eq("illegal_op", 32'(illegal_op), 32'(exp_ill));
    check_eq("bus_error", 32'(bus_error), 32'(exp_berr));
    if (ret) exp_cnt = (exp_cnt + 1) % (1 << RW);
  endtask

  // One clock cycle in which the sequencer is expected to sit in state st.
  task automatic step(input logic [2:0] st, input logic rdy, input logic hreq, input logic [6:0] op);
    @(negedge clk);
    mem_ready = rdy;
    halt_req  = hreq;
    opcode    = op;
    #1;
    check_outputs(st, rdy, op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; opcode = 7'd0;
    exp_cnt = 0; exp_ill = 1'b0; exp_berr = 1'b0;
    @(negedge clk);
    #1;
    check_outputs(3'd0, 1'b0, 7'd0);
    reset = 1'b1;
    #1;
    check_eq("idle_after_release", 32'(state), 32'd0);
  endtask

  // Timeline of one instruction: fetch waits, decode, execute, optional mem waits, writeback, halt.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic hflag, input int hwait);
    logic is_mem;
    is_mem = (op == OP_LD) || (op == OP_ST);
    for (int i = 0; i <= fw; i++) step(3'd1, (i == fw), 1'($urandom), op);
    step(3'd2, 1'($urandom), 1'($urandom), op);
    step(3'd3, 1'($urandom), 1'($urandom), op);
    if (is_mem) begin
      for (int i = 0; i <= mw; i++)
        step(3'd4, (i == mw), ((i == mw) && (op == OP_ST)) ? hflag : 1'($urandom), op);
    end
    if (op != OP_ST) step(3'd5, 1'($urandom), hflag, op);
    if (hflag) begin
      for (int i = 0; i < hwait; i++) step(3'd6, 1'($urandom), 1'b1, op);
      step(3'd6, 1'($urandom), 1'b0, op);
    end
  endtask

  initial begin
    logic [6:0] ops [4];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST;
    reset = 1'b1; mem_ready = 1'b0; halt_req = 1'b0; opcode = 7'd0;
    exp_cnt = 0; exp_ill = 1'b0; exp_berr = 1'b0;
    #1 reset = 1'b0;

    // Directed minimum-latency ALU, load with two wait states, and store.
    do_reset();
    run_instr(OP_R, 0, 0, 1'b0, 0);
    run_instr(OP_LD, 0, 2, 1'b0, 0);
    run_instr(OP_ST, 0, 0, 1'b1, 2);

    for (int n = 0; n < 150; n++)
      run_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 2));

    // Illegal opcode halts permanently until reset.
    do_reset();
    step(3'd1, 1'b1, 1'b0, OP_BAD);
    step(3'd2, 1'b0, 1'b0, OP_BAD);
    exp_ill = 1'b1;
    for (int i = 0; i < 6; i++) step(3'd6, 1'($urandom), 1'(i % 2), OP_BAD);

    // Memory never answers during fetch.
    do_reset();
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++) step(3'd1, 1'b0, 1'b0, OP_R);
    exp_berr = 1'b1;
    for (int i = 0; i < 4; i++) step(3'd6, 1'b0, 1'b0, OP_R);
`else
    for (int i = 0; i < 20; i++) step(3'd1, 1'b0, 1'b0, OP_R);
`endif

    // Reset in the middle of a load's memory access.
    do_reset();
    run_instr(OP_R, 0, 0, 1'b0, 0);
    step(3'd1, 1'b1, 1'b0, OP_LD);
    step(3'd2, 1'b0, 1'b0, OP_LD);
    step(3'd3, 1'b0, 1'b0, OP_LD);
    step(3'd4, 1'b0, 1'b0, OP_LD);
    @(negedge clk);
    mem_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_ir_write_en", 32'(ir_write_en), 32'd0);
    check_eq("rst_retire_count", 32'(retire_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
